axi4_stream_to_axi4: RTL and testbench

Frame-buffer write engine. Accepts one AXI4-Stream packet per arm strobe and writes it to memory starting at a word-aligned address, using AXI4 INCR write bursts. Each burst is staged in an internal FIFO before the address is issued, because awlen must be known first. On completion it reports the byte count and any error. It is the write-side counterpart of the frame-buffer stream reader.

---
 rtl/axi4_stream_to_axi4_pkg.sv | 17 +
 rtl/axi4_stream_to_axi4_if.sv | 86 ++++++++
 rtl/axi4_stream_to_axi4_sync_fifo.sv | 47 ++++
 rtl/axi4_stream_to_axi4.sv | 246 ++++++++++++++++++++++++
 tb/tb_axi4_stream_to_axi4.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/axi4_stream_to_axi4_pkg.sv
// Shared constants and state type for the stream-to-AXI4 frame-buffer writer.
package axi4_stream_to_axi4_pkg;

  localparam logic [1:0]  BURST_INCR      = 2'b01;
  localparam logic [1:0]  RESP_OKAY       = 2'b00;
  localparam int unsigned MAX_BURST_BEATS = 256;
  localparam int unsigned BOUNDARY_4K     = 4096;

  typedef enum logic [2:0] {
    IDLE_S,
    FILL_S,
    ADDR_S,
    DATA_S,
    RESP_S
  } state_e;

endpackage

// File: rtl/axi4_stream_to_axi4_if.sv
// AXI4-Stream and AXI4 (full) interface bundles used by the frame-buffer engines.
interface axi4_stream_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;
  logic [ID_WIDTH-1:0]     tid;
  logic [DEST_WIDTH-1:0]   tdest;
  logic [USER_WIDTH-1:0]   tuser;

  modport master (output tdata, tkeep, tlast, tvalid, tid, tdest, tuser, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, tid, tdest, tuser, output tready);
endinterface

interface axi4_if #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned ID_WIDTH     = 1,
  parameter int unsigned AWUSER_WIDTH = 1,
  parameter int unsigned WUSER_WIDTH  = 1,
  parameter int unsigned ARUSER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic [AWUSER_WIDTH-1:0] awuser;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic [WUSER_WIDTH-1:0]  wuser;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic [ARUSER_WIDTH-1:0] aruser;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
           awuser, awvalid, wdata, wstrb, wlast, wuser, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
           aruser, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
           awuser, awvalid, wdata, wstrb, wlast, wuser, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
           aruser, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_stream_to_axi4_sync_fifo.sv
// Single-clock FIFO with show-ahead read port; DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/axi4_stream_to_axi4.sv
// Frame-buffer write engine: stages each stream burst in a FIFO, then writes it
// with an AXI4 INCR burst that never crosses a 4 KB boundary.
module axi4_stream_to_axi4
  import axi4_stream_to_axi4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 64,
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned ID_WIDTH           = 1,
  parameter int unsigned AWUSER_WIDTH       = 1,
  parameter int unsigned WUSER_WIDTH        = 1,
  parameter int unsigned ARUSER_WIDTH       = 1,
  parameter int unsigned TUSER_WIDTH        = 1,
  parameter int unsigned TDEST_WIDTH        = 1,
  parameter int unsigned MAX_PKT_SIZE_B     = 2048,
  parameter int unsigned MAX_PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [ADDR_WIDTH-1:0]       addr_i,
  input  logic                        wr_stb_i,
  axi4_stream_if.slave                pkt_i,
  axi4_if.master                      mem_o,
  output logic [MAX_PKT_SIZE_WIDTH:0] pkt_size_o,
  output logic                        done_o,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS   = $clog2(STRB_W);
  localparam int unsigned FIFO_W = DATA_WIDTH + STRB_W;
  localparam int unsigned BEAT_W = $clog2(MAX_BURST_BEATS) + 1;
  localparam int unsigned CNT_W  = MAX_PKT_SIZE_WIDTH + 1;
  localparam int unsigned KEEP_W = $clog2(STRB_W) + 1;

  function automatic logic [KEEP_W-1:0] popcount(input logic [STRB_W-1:0] v);
    logic [KEEP_W-1:0] n;
    n = '0;
    for (int i = 0; i < STRB_W; i++) n = n + KEEP_W'(v[i]);
    return n;
  endfunction

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q, awaddr_q;
  logic [BEAT_W-1:0]     beat_cnt_q;
  logic [CNT_W-1:0]      byte_cnt_q;
  logic [7:0]            awlen_q, w_left_q;
  logic                  awvalid_q, wvalid_q, wlast_q, bready_q, tready_q;
  logic                  done_q, err_q, ovf_q, last_seen_q;

  logic [12:0]           room_beats;
  logic [BEAT_W-1:0]     burst_max;
  logic [CNT_W-1:0]      byte_sum;
  logic                  oversize, tready, t_hs, push, aw_hs, w_hs, b_hs;
  logic                  fifo_full, fifo_empty;
  logic [FIFO_W-1:0]     fifo_rdata;

  // Beats left before the next 4 KB boundary, capped at the AXI burst limit.
  assign room_beats = (13'(BOUNDARY_4K) - 13'(cur_addr_q[11:0])) >> OFFS;
  assign burst_max  = (room_beats > 13'(MAX_BURST_BEATS)) ? BEAT_W'(MAX_BURST_BEATS)
                                                          : BEAT_W'(room_beats);

  assign byte_sum = byte_cnt_q + CNT_W'(popcount(pkt_i.tkeep));
  assign oversize = (byte_sum > CNT_W'(MAX_PKT_SIZE_B));
  assign tready   = tready_q && !fifo_full;
  assign t_hs     = pkt_i.tvalid && tready;
  assign push     = t_hs && !ovf_q && !oversize;
  assign aw_hs    = awvalid_q && mem_o.awready;
  assign w_hs     = wvalid_q && !fifo_empty && mem_o.wready;
  assign b_hs     = bready_q && mem_o.bvalid;

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (MAX_BURST_BEATS)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  ({pkt_i.tdata, pkt_i.tkeep}),
    .pop_i   (w_hs),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE_S;
      cur_addr_q  <= '0;
      awaddr_q    <= '0;
      beat_cnt_q  <= '0;
      byte_cnt_q  <= '0;
      awlen_q     <= '0;
      w_left_q    <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
      tready_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE_S: begin
          if (wr_stb_i) begin
            cur_addr_q  <= {addr_i[ADDR_WIDTH-1:OFFS], OFFS'(0)};
            beat_cnt_q  <= '0;
            byte_cnt_q  <= '0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            last_seen_q <= 1'b0;
            tready_q    <= 1'b1;
            state_q     <= FILL_S;
          end
        end
        FILL_S: begin
          if (t_hs) begin
            if (ovf_q) begin
              // Draining an oversize packet: nothing is pending, finish at tlast.
              if (pkt_i.tlast) begin
                tready_q <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= IDLE_S;
              end
            end else if (oversize) begin
              err_q <= 1'b1;
              ovf_q <= 1'b1;
              if (beat_cnt_q != '0) begin
                last_seen_q <= pkt_i.tlast;
                tready_q    <= 1'b0;
                awvalid_q   <= 1'b1;
                awaddr_q    <= cur_addr_q;
                awlen_q     <= 8'(beat_cnt_q - BEAT_W'(1));
                state_q     <= ADDR_S;
              end else if (pkt_i.tlast) begin
                tready_q <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= IDLE_S;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
              byte_cnt_q <= byte_sum;
              if (pkt_i.tlast || (beat_cnt_q + BEAT_W'(1) == burst_max)) begin
                last_seen_q <= pkt_i.tlast;
                tready_q    <= 1'b0;
                awvalid_q   <= 1'b1;
                awaddr_q    <= cur_addr_q;
                awlen_q     <= 8'(beat_cnt_q);
                state_q     <= ADDR_S;
              end
            end
          end
        end
        ADDR_S: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= (awlen_q == 8'd0);
            w_left_q  <= awlen_q;
            state_q   <= DATA_S;
          end
        end
        DATA_S: begin
          if (w_hs) begin
            cur_addr_q <= cur_addr_q + ADDR_WIDTH'(STRB_W);
            w_left_q   <= w_left_q - 8'd1;
            wlast_q    <= (w_left_q == 8'd1);
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              state_q  <= RESP_S;
            end
          end
        end
        RESP_S: begin
          if (b_hs) begin
            bready_q <= 1'b0;
            if (mem_o.bresp != RESP_OKAY) err_q <= 1'b1;
            if (last_seen_q) begin
              done_q  <= 1'b1;
              state_q <= IDLE_S;
            end else begin
              beat_cnt_q <= '0;
              tready_q   <= 1'b1;
              state_q    <= FILL_S;
            end
          end
        end
        default: state_q <= IDLE_S;
      endcase
    end
  end

  assign pkt_i.tready   = tready;
  assign pkt_size_o     = byte_cnt_q;
  assign done_o         = done_q;
  assign busy_o         = (state_q != IDLE_S);
  assign err_o          = err_q;

  assign mem_o.awid     = ID_WIDTH'(0);
  assign mem_o.awaddr   = awaddr_q;
  assign mem_o.awlen    = awlen_q;
  assign mem_o.awsize   = 3'(OFFS);
  assign mem_o.awburst  = BURST_INCR;
  assign mem_o.awlock   = 1'b0;
  assign mem_o.awcache  = 4'd0;
  assign mem_o.awprot   = 3'd0;
  assign mem_o.awqos    = 4'd0;
  assign mem_o.awregion = 4'd0;
  assign mem_o.awuser   = AWUSER_WIDTH'(0);
  assign mem_o.awvalid  = awvalid_q;
  assign mem_o.wdata    = fifo_rdata[FIFO_W-1:STRB_W];
  assign mem_o.wstrb    = fifo_rdata[STRB_W-1:0];
  assign mem_o.wlast    = wlast_q;
  assign mem_o.wuser    = WUSER_WIDTH'(0);
  assign mem_o.wvalid   = wvalid_q && !fifo_empty;
  assign mem_o.bready   = bready_q;

  // Write-only engine: read channel permanently idle.
  assign mem_o.arid     = ID_WIDTH'(0);
  assign mem_o.araddr   = '0;
  assign mem_o.arlen    = 8'd0;
  assign mem_o.arsize   = 3'd0;
  assign mem_o.arburst  = 2'b00;
  assign mem_o.arlock   = 1'b0;
  assign mem_o.arcache  = 4'd0;
  assign mem_o.arprot   = 3'd0;
  assign mem_o.arqos    = 4'd0;
  assign mem_o.arregion = 4'd0;
  assign mem_o.aruser   = ARUSER_WIDTH'(0);
  assign mem_o.arvalid  = 1'b0;
  assign mem_o.rready   = 1'b1;

  logic [TUSER_WIDTH-1:0] unused_tuser;
  logic [TDEST_WIDTH-1:0] unused_tdest;
  logic                   unused_misc;
  assign unused_tuser = pkt_i.tuser;
  assign unused_tdest = pkt_i.tdest;
  assign unused_misc  = ^{addr_i[OFFS-1:0], pkt_i.tid, mem_o.bid, mem_o.arready, mem_o.rid,
                          mem_o.rdata, mem_o.rresp, mem_o.rlast, mem_o.rvalid};

endmodule

// File: tb/tb_axi4_stream_to_axi4.sv
// Directed and randomized packets against a byte-level memory model and burst plan.
module tb_axi4_stream_to_axi4;

  localparam int MAXB   = 2048;
  localparam int BUDGET = 20000;
  localparam int MEMSZ  = 16384;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        wr_stb;
  logic [11:0] pkt_size;
  logic        done, busy, err;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  int slverr_left = 0;
  bit stall = 1'b0;

  logic [7:0] mem     [MEMSZ];
  logic [7:0] exp_mem [MEMSZ];
  int log_addr[$], log_len[$];

  always #5 clk = ~clk;

  axi4_stream_if #(.DATA_WIDTH(64), .ID_WIDTH(1), .DEST_WIDTH(1), .USER_WIDTH(1)) s_if ();
  axi4_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .ID_WIDTH(1),
            .AWUSER_WIDTH(1), .WUSER_WIDTH(1), .ARUSER_WIDTH(1)) m_if ();

  axi4_stream_to_axi4 #(
    .DATA_WIDTH(64), .ADDR_WIDTH(32), .ID_WIDTH(1), .AWUSER_WIDTH(1), .WUSER_WIDTH(1),
    .ARUSER_WIDTH(1), .TUSER_WIDTH(1), .TDEST_WIDTH(1), .MAX_PKT_SIZE_B(2048),
    .MAX_PKT_SIZE_WIDTH(11)
  ) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .wr_stb_i(wr_stb),
    .pkt_i(s_if), .mem_o(m_if),
    .pkt_size_o(pkt_size), .done_o(done), .busy_o(busy), .err_o(err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory slave: all decisions made at negedge; DUT valids/readies are registered,
  // so a handshake computed here is the one that completes at the next posedge.
  initial begin
    int aq_addr[$], aq_len[$];
    logic [1:0] aq_resp[$], bq[$];
    int w_idx;
    bit b_hold;
    int a;
    w_idx = 0; b_hold = 0;
    m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = 0; m_if.bid = 0;
    m_if.arready = 0; m_if.rid = 0; m_if.rdata = 0; m_if.rresp = 0; m_if.rlast = 0;
    m_if.rvalid = 0;
    forever begin
      @(negedge clk);
      if (!b_hold) begin
        if (bq.size() > 0 && (!stall || $urandom_range(0, 2) == 0)) begin
          m_if.bvalid = 1; m_if.bresp = bq.pop_front(); b_hold = 1;
        end else m_if.bvalid = 0;
      end
      if (m_if.bvalid && m_if.bready) b_hold = 0;

      m_if.wready = !stall || ($urandom_range(0, 1) == 0);
      if (m_if.wvalid) begin
        if (aq_addr.size() == 0) viol++;
        else if (m_if.wready) begin
          a = aq_addr[0] + w_idx * 8;
          for (int l = 0; l < 8; l++)
            if (m_if.wstrb[l]) mem[(a + l) % MEMSZ] = m_if.wdata[8*l +: 8];
          if (m_if.wlast !== (w_idx == aq_len[0])) viol++;
          if (w_idx == aq_len[0]) begin
            bq.push_back(aq_resp[0]);
            void'(aq_addr.pop_front()); void'(aq_len.pop_front()); void'(aq_resp.pop_front());
            w_idx = 0;
          end else w_idx++;
        end
      end

      m_if.awready = !stall || ($urandom_range(0, 1) == 0);
      if (m_if.awvalid && m_if.awready) begin
        if (m_if.awsize !== 3'd3 || m_if.awburst !== 2'b01) viol++;
        aq_addr.push_back(int'(m_if.awaddr));
        aq_len.push_back(int'(m_if.awlen));
        aq_resp.push_back(slverr_left > 0 ? 2'b10 : 2'b00);
        if (slverr_left > 0) slverr_left--;
        log_addr.push_back(int'(m_if.awaddr));
        log_len.push_back(int'(m_if.awlen));
      end
    end
  end

  task automatic run_pkt(input logic [31:0] base, input int len, input bit gaps,
                         input int stb_mid, input bit exp_slverr);
    int nb, k, bytes, wbeats, a, n, chunk, idx, cyc, miss;
    bit ovs, stb_done;
    logic [63:0] d;
    logic [63:0] bd[$];
    logic [7:0]  bk[$];
    int ea[$], el[$];
    nb = (len + 7) / 8;
    for (int i = 0; i < MEMSZ; i++) begin mem[i] = 8'h00; exp_mem[i] = 8'h00; end
    bytes = 0; wbeats = 0; ovs = 0;
    // Reference: only whole beats that keep the running total within MAXB land in memory.
    for (int b = 0; b < nb; b++) begin
      k = (b == nb - 1 && len % 8 != 0) ? len % 8 : 8;
      d = {$urandom, $urandom};
      bd.push_back(d);
      bk.push_back(8'((1 << k) - 1));
      if (!ovs && bytes + k <= MAXB) begin
        for (int l = 0; l < k; l++) exp_mem[(int'(base) + b * 8 + l) % MEMSZ] = d[8*l +: 8];
        bytes += k; wbeats++;
      end else ovs = 1;
    end
    a = int'(base); n = wbeats;
    while (n > 0) begin
      chunk = (4096 - (a % 4096)) / 8;
      if (chunk > 256) chunk = 256;
      if (chunk > n) chunk = n;
      ea.push_back(a); el.push_back(chunk - 1);
      a += chunk * 8; n -= chunk;
    end
    log_addr.delete(); log_len.delete(); viol = 0;
    slverr_left = exp_slverr ? 1 : 0;

    addr = base; wr_stb = 1;
    @(negedge clk);
    wr_stb = 0;
    chk("arm_busy", busy, 1);
    chk("arm_err_clr", err, 0);
    chk("arm_size_clr", pkt_size, 0);

    idx = 0; cyc = 0; stb_done = 0;
    while (idx < nb && cyc < BUDGET) begin
      s_if.tvalid = !(gaps && $urandom_range(0, 2) == 0);
      s_if.tdata  = bd[idx];
      s_if.tkeep  = bk[idx];
      s_if.tlast  = (idx == nb - 1);
      if (!stb_done && stb_mid >= 0 && idx == stb_mid) begin
        addr = 32'h3000; wr_stb = 1; stb_done = 1;
      end else wr_stb = 0;
      if (s_if.tvalid && s_if.tready) idx++;
      @(negedge clk);
      cyc++;
    end
    s_if.tvalid = 0; s_if.tlast = 0; wr_stb = 0;
    chk("stream_consumed", idx, nb);

    for (cyc = 0; cyc < BUDGET && done !== 1'b1; cyc++) @(negedge clk);
    chk("done_seen", done, 1);
    chk("pkt_size", pkt_size, bytes);
    chk("err", err, ovs || exp_slverr);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle", busy, 0);
    chk("size_hold", pkt_size, bytes);
    chk("burst_count", log_addr.size(), ea.size());
    for (int i = 0; i < ea.size() && i < log_addr.size(); i++) begin
      chk("burst_addr", log_addr[i], ea[i]);
      chk("burst_len", log_len[i], el[i]);
    end
    chk("protocol", viol, 0);
    miss = 0;
    for (int i = 0; i < MEMSZ; i++) if (mem[i] !== exp_mem[i]) miss++;
    chk("mem_bytes", miss, 0);
  endtask

  initial begin
    rst = 1; addr = 0; wr_stb = 0;
    s_if.tvalid = 0; s_if.tdata = 0; s_if.tkeep = 0; s_if.tlast = 0;
    s_if.tid = 0; s_if.tdest = 0; s_if.tuser = 0;
    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_size", pkt_size, 0);
    chk("rst_awvalid", m_if.awvalid, 0);
    chk("rst_wvalid", m_if.wvalid, 0);
    chk("rst_tready", s_if.tready, 0);
    chk("rst_arvalid", m_if.arvalid, 0);
    chk("rst_rready", m_if.rready, 1);
    rst = 0;
    @(negedge clk);
    chk("idle_tready", s_if.tready, 0);

    run_pkt(32'h0000_1000, 64, 0, -1, 0);
    run_pkt(32'h0000_0000, 2048, 0, -1, 0);
    run_pkt(32'h0000_0FF0, 100, 0, -1, 0);

    stall = 1;
    run_pkt(32'($urandom_range(0, 1023) * 8), 1000, 1, 3, 0);

    run_pkt(32'h0000_0FF0, 100, 1, -1, 1);
    repeat (5) @(negedge clk);
    chk("err_sticky", err, 1);
    run_pkt(32'h0000_0200, 40, 1, -1, 0);

    run_pkt(32'h0000_0000, 2100, 1, -1, 0);
    run_pkt(32'h0000_0F00, 2060, 1, -1, 0);

    for (int t = 0; t < 4; t++)
      run_pkt(32'($urandom_range(0, 1023) * 8), int'($urandom_range(1, 2200)), 1, -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
